control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired Moore control unit that drives the datapath control strobes (Gra/Grb/Grc, Rin/Rout, *in/*out,
//  Read/Write, IncPC, CONin, opcode). Each instruction runs as a fetch (T0-T2) followed by an
//  opcode-specific execute (T3-T7), one state per clock. It replaces per-instruction bench sequencing
//  and sits between the datapath (IR opcode, CON_FF in; strobes out) and the top level (Stop in, Run out).
// PARAMETERS
//  ADD_OP           5'b00011  ALU code forced on opcode during address/PC-offset adds
//  HALT_ON_ILLEGAL  1         1: undefined opcode -> HALTED; 0: undefined opcode executes as nop
// PORTS
//  Clock        in   1  system clock, all state updates on rising edge
//  clear        in   1  synchronous active-high reset; also resets the datapath
//  ir_opcode    in   5  IR[31:27], valid from T3 onward
//  con_ff       in   1  datapath CON_FF output (branch condition), valid from T4
//  Stop         in   1  halt request, checked only at instruction boundaries
//  Run          out  1  1 = executing; 0 in RESET and HALTED
//  opcode       out  5  ALU operation to datapath: ADD_OP in address states, else ir_opcode
//  Gra,Grb,Grc,Rin,Rout,BAout                      out 1 each  register-file select/enable strobes
//  PCin,PCout,IncPC,MARin,MDRin,MDRout,IRin        out 1 each  PC/memory-interface strobes
//  Yin,Zin,Zlowout,Zhighout,HIin,LOin,HIout,LOout  out 1 each  ALU/HI/LO strobes
//  Cout,CONin,Inportout,Outportin,Read,Write       out 1 each  constant/branch/IO/memory strobes
// BEHAVIOUR
//  - States: RESET, T0..T7, HALTED. Registered state; all outputs decoded from state (+ir_opcode, con_ff).
//  - clear=1 at any edge -> RESET next cycle, from any state. In-flight instruction is abandoned; Write is
//    never asserted in the cycle after clear is sampled. RESET: every output 0, opcode=0, Run=0.
//  - RESET -> T0 when clear=0. HALTED is left only via clear; HALTED outputs match RESET.
//  - Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111,
//    shl 01000, addi 01001, andi 01010, ori 01011, mul 01100, br 10010, jr 10011, in 10101, out 10110,
//    mfhi 10111, mflo 11000, nop 11001, halt 11010. All other codes are undefined.
//  - Fetch: T0 PCout,MARin | T1 Read,MDRin | T2 MDRout,IRin,PCin,IncPC.
//  - Execute (strobes listed are the only ones high; last listed step returns to T0):
//    add/sub/and/or/shr/shl: T3 Grb,Rout,Yin | T4 Grc,Rout,Zin | T5 Zlowout,Gra,Rin
//    mul: T3 Grb,Rout,Yin | T4 Grc,Rout,Zin | T5 Zlowout,LOin | T6 Zhighout,HIin
//    addi/andi/ori: T3 Grb,Rout,Yin | T4 Cout,Zin | T5 Zlowout,Gra,Rin
//    ldi: T3 Grb,BAout,Yin | T4 Cout,Zin[ADD_OP] | T5 Zlowout,Gra,Rin
//    ld: as ldi T3-T4 | T5 Zlowout,MARin | T6 Read,MDRin | T7 MDRout,Gra,Rin
//    st: as ldi T3-T4 | T5 Zlowout,MARin | T6 Gra,Rout,MDRin (Read=0) | T7 Write
//    br: T3 Gra,Rout,CONin | T4 PCout,Yin | T5 Cout,Zin[ADD_OP] | T6 Zlowout, PCin=con_ff
//    jr: T3 Gra,Rout,PCin   in: T3 Inportout,Gra,Rin   out: T3 Gra,Rout,Outportin
//    mfhi: T3 HIout,Gra,Rin   mflo: T3 LOout,Gra,Rin   nop: T3 (all idle)   halt: T3 -> HALTED
//  - opcode = ADD_OP in ld/ldi/st T4 and br T5; ir_opcode in all other T3-T7; 0 in RESET/T0-T2/HALTED.
//  - Undefined opcode in T3: HALT_ON_ILLEGAL=1 -> HALTED next; 0 -> behaves as nop.
//  - Instruction boundary = transition from last execute step toward T0: if Stop=1 go to HALTED, else T0.
//    Stop is ignored at all other times.
//  - Write and Read are never high together; Write only in st T7; Read only in T1 and ld T6.
//  - Latency (cycles incl. fetch): jr/in/out/mfhi/mflo/nop 4, alu/imm/ldi 6, mul/br 7, ld/st 8.
// TESTING
//  - Reset: clear=1 two cycles, release -> 1 cycle RESET (all 0, Run=0), then T0 PCout=MARin=1, Run=1.
//  - add r1,r2,r3 (ir_opcode=00011) -> T3 Grb/Rout/Yin, T4 Grc/Rout/Zin with opcode=00011, T5 Zlowout/Gra/Rin, next T0.
//  - br (10010): con_ff=1 -> T6 PCin=1; con_ff=0 -> T6 PCin=0, Zlowout=1; both give opcode=ADD_OP in T5.
//  - st (00010) -> Write=1 in T7 only; assert clear in T6 of a second st -> Write stays 0 and RESET follows.
//  - Stop=1 raised mid-ld -> ld completes (T7 MDRout/Gra/Rin) then HALTED, Run=0; clear restarts at T0.
//  - ir_opcode=11111: HALT_ON_ILLEGAL=1 -> HALTED after T3; =0 -> returns to T0 with no strobes in T3.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control strobe bundle between the sequencer (master) and the datapath (slave).
interface control_sequencer_if;
  localparam int unsigned OP_W = 5;

  logic [OP_W-1:0] ir_opcode;
  logic            con_ff;
  logic            Stop;
  logic            Run;
  logic [OP_W-1:0] opcode;

  logic Gra, Grb, Grc, Rin, Rout, BAout;
  logic PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
  logic Cout, CONin, Inportout, Outportin, Read, Write;

  modport master (
    input  ir_opcode, con_ff, Stop,
    output Run, opcode,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin,
    output Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
    output Cout, CONin, Inportout, Outportin, Read, Write
  );

  modport slave (
    output ir_opcode, con_ff, Stop,
    input  Run, opcode,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin,
    input  Yin, Zin, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
    input  Cout, CONin, Inportout, Outportin, Read, Write
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, opcode-specific execute T3-T7.
// Strobes are decoded from the state register plus the IR opcode, which only
// becomes valid once the state reaches T3.
module control_sequencer #(
  parameter logic [4:0] ADD_OP          = 5'b00011,
  parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
  input logic                 Clock,
  input logic                 clear,
  control_sequencer_if.master bus
);
  localparam int unsigned OP_W = 5;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    C_ALU, C_MUL, C_IMM, C_LDI, C_LD, C_ST, C_BR, C_JR,
    C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_HALT, C_ILL
  } iclass_e;

  state_e  state;
  state_e  after_last;
  iclass_e cls;

  // Classify the opcode into groups sharing an execute sequence.
  always_comb begin
    cls = C_ILL;
    case (bus.ir_opcode)
      5'b00011, 5'b00100, 5'b00101,
      5'b00110, 5'b00111, 5'b01000: cls = C_ALU;
      5'b01100:                     cls = C_MUL;
      5'b01001, 5'b01010, 5'b01011: cls = C_IMM;
      5'b00001:                     cls = C_LDI;
      5'b00000:                     cls = C_LD;
      5'b00010:                     cls = C_ST;
      5'b10010:                     cls = C_BR;
      5'b10011:                     cls = C_JR;
      5'b10101:                     cls = C_IN;
      5'b10110:                     cls = C_OUT;
      5'b10111:                     cls = C_MFHI;
      5'b11000:                     cls = C_MFLO;
      5'b11001:                     cls = C_NOP;
      5'b11010:                     cls = C_HALT;
      default:                      cls = C_ILL;
    endcase
  end

  // Stop is honoured only at an instruction boundary.
  assign after_last = bus.Stop ? S_HALTED : S_T0;

  // State sequencing; clear wins from any state.
  always_ff @(posedge Clock) begin
    if (clear) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET:  state <= S_T0;
        S_T0:     state <= S_T1;
        S_T1:     state <= S_T2;
        S_T2:     state <= S_T3;
        S_T3: begin
          if (cls == C_HALT || (cls == C_ILL && HALT_ON_ILLEGAL))
            state <= S_HALTED;
          else if (cls inside {C_JR, C_IN, C_OUT, C_MFHI, C_MFLO, C_NOP, C_ILL})
            state <= after_last;
          else
            state <= S_T4;
        end
        S_T4:     state <= S_T5;
        S_T5:     state <= (cls inside {C_ALU, C_IMM, C_LDI}) ? after_last : S_T6;
        S_T6:     state <= (cls inside {C_MUL, C_BR}) ? after_last : S_T7;
        S_T7:     state <= after_last;
        S_HALTED: state <= S_HALTED;
        default:  state <= S_RESET;
      endcase
    end
  end

  // Strobe decode; every strobe idles low unless the current step names it.
  always_comb begin
    bus.Run = 1'b0;  bus.opcode = OP_W'(0);
    bus.Gra = 1'b0;  bus.Grb = 1'b0;  bus.Grc = 1'b0;  bus.Rin = 1'b0;
    bus.Rout = 1'b0; bus.BAout = 1'b0;
    bus.PCin = 1'b0; bus.PCout = 1'b0; bus.IncPC = 1'b0; bus.MARin = 1'b0;
    bus.MDRin = 1'b0; bus.MDRout = 1'b0; bus.IRin = 1'b0;
    bus.Yin = 1'b0;  bus.Zin = 1'b0;  bus.Zlowout = 1'b0; bus.Zhighout = 1'b0;
    bus.HIin = 1'b0; bus.LOin = 1'b0; bus.HIout = 1'b0; bus.LOout = 1'b0;
    bus.Cout = 1'b0; bus.CONin = 1'b0; bus.Inportout = 1'b0; bus.Outportin = 1'b0;
    bus.Read = 1'b0; bus.Write = 1'b0;

    if (state != S_RESET && state != S_HALTED) bus.Run = 1'b1;
    if (state inside {S_T3, S_T4, S_T5, S_T6, S_T7}) bus.opcode = bus.ir_opcode;

    case (state)
      S_T0: begin bus.PCout = 1'b1; bus.MARin = 1'b1; end
      S_T1: begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
      S_T2: begin bus.MDRout = 1'b1; bus.IRin = 1'b1; bus.PCin = 1'b1; bus.IncPC = 1'b1; end
      S_T3: begin
        case (cls)
          C_ALU, C_MUL, C_IMM: begin bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1; end
          C_LDI, C_LD, C_ST:   begin bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1; end
          C_BR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1; end
          C_JR:   begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1; end
          C_IN:   begin bus.Inportout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_OUT:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Outportin = 1'b1; end
          C_MFHI: begin bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_MFLO: begin bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU, C_MUL:      begin bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; end
          C_IMM:             begin bus.Cout = 1'b1; bus.Zin = 1'b1; end
          C_LDI, C_LD, C_ST: begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = ADD_OP; end
          C_BR:              begin bus.PCout = 1'b1; bus.Yin = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU, C_IMM, C_LDI: begin bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_MUL:       begin bus.Zlowout = 1'b1; bus.LOin = 1'b1; end
          C_LD, C_ST:  begin bus.Zlowout = 1'b1; bus.MARin = 1'b1; end
          C_BR:        begin bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = ADD_OP; end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          C_MUL: begin bus.Zhighout = 1'b1; bus.HIin = 1'b1; end
          C_LD:  begin bus.Read = 1'b1; bus.MDRin = 1'b1; end
          C_ST:  begin bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1; end
          C_BR:  begin bus.Zlowout = 1'b1; bus.PCin = bus.con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          C_LD: begin bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1; end
          C_ST: bus.Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: two instances (halt / nop on undefined opcode,
// different forced ALU codes) checked every cycle against a per-instruction
// step table built from the instruction set description.
module tb_control_sequencer;
  localparam logic [4:0] ADD1 = 5'b00011;
  localparam logic [4:0] ADD0 = 5'b11110;

  localparam int P_GRA = 0,  P_GRB = 1,  P_GRC = 2,  P_RIN = 3,  P_ROUT = 4,  P_BAOUT = 5;
  localparam int P_PCIN = 6, P_PCOUT = 7, P_INCPC = 8, P_MARIN = 9, P_MDRIN = 10;
  localparam int P_MDROUT = 11, P_IRIN = 12, P_YIN = 13, P_ZIN = 14, P_ZLO = 15, P_ZHI = 16;
  localparam int P_HIIN = 17, P_LOIN = 18, P_HIOUT = 19, P_LOOUT = 20, P_COUT = 21;
  localparam int P_CONIN = 22, P_INP = 23, P_OUTP = 24, P_READ = 25, P_WRITE = 26;

  localparam logic [1:0] K_ZERO = 2'd0, K_IR = 2'd1, K_ADD = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [26:0] s;
  } step_t;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [4:0] ir_opcode = 5'b0;
  logic       con_ff = 1'b0;
  logic       stop = 1'b0;

  int checks = 0;
  int errors = 0;

  step_t exp_q[$];
  bit    op_halt, op_ill;
  logic [4:0] legal [21];

  control_sequencer_if b1 ();
  control_sequencer_if b0 ();

  assign b1.ir_opcode = ir_opcode; assign b1.con_ff = con_ff; assign b1.Stop = stop;
  assign b0.ir_opcode = ir_opcode; assign b0.con_ff = con_ff; assign b0.Stop = stop;

  control_sequencer #(.ADD_OP(ADD1), .HALT_ON_ILLEGAL(1'b1)) dut1 (.Clock(clk), .clear(clear), .bus(b1));
  control_sequencer #(.ADD_OP(ADD0), .HALT_ON_ILLEGAL(1'b0)) dut0 (.Clock(clk), .clear(clear), .bus(b0));

  logic [32:0] obs1, obs0;
  assign obs1 = {b1.Run, b1.opcode, b1.Write, b1.Read, b1.Outportin, b1.Inportout, b1.CONin,
                 b1.Cout, b1.LOout, b1.HIout, b1.LOin, b1.HIin, b1.Zhighout, b1.Zlowout, b1.Zin,
                 b1.Yin, b1.IRin, b1.MDRout, b1.MDRin, b1.MARin, b1.IncPC, b1.PCout, b1.PCin,
                 b1.BAout, b1.Rout, b1.Rin, b1.Grc, b1.Grb, b1.Gra};
  assign obs0 = {b0.Run, b0.opcode, b0.Write, b0.Read, b0.Outportin, b0.Inportout, b0.CONin,
                 b0.Cout, b0.LOout, b0.HIout, b0.LOin, b0.HIin, b0.Zhighout, b0.Zlowout, b0.Zin,
                 b0.Yin, b0.IRin, b0.MDRout, b0.MDRin, b0.MARin, b0.IncPC, b0.PCout, b0.PCin,
                 b0.BAout, b0.Rout, b0.Rin, b0.Grc, b0.Grb, b0.Gra};

  always #5 clk = ~clk;

  function automatic logic [26:0] b(input int p);
    return 27'(1) << p;
  endfunction

  function automatic logic [32:0] expv(input step_t st, input logic [4:0] op, input logic [4:0] addop);
    logic [4:0] o;
    o = (st.kind == K_IR) ? op : (st.kind == K_ADD) ? addop : 5'b0;
    return {1'b1, o, st.s};
  endfunction

  localparam logic [32:0] ZERO_V = 33'b0;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [26:0] m);
    step_t st;
    st.kind = k;
    st.s    = m;
    exp_q.push_back(st);
  endtask

  // Expected step list for one instruction, straight from the instruction table.
  task automatic build(input logic [4:0] op, input logic con);
    exp_q.delete();
    op_halt = 1'b0;
    op_ill  = 1'b0;
    push(K_ZERO, b(P_PCOUT) | b(P_MARIN));
    push(K_ZERO, b(P_READ) | b(P_MDRIN));
    push(K_ZERO, b(P_MDROUT) | b(P_IRIN) | b(P_PCIN) | b(P_INCPC));
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000: begin
        push(K_IR, b(P_GRB) | b(P_ROUT) | b(P_YIN));
        push(K_IR, b(P_GRC) | b(P_ROUT) | b(P_ZIN));
        push(K_IR, b(P_ZLO) | b(P_GRA) | b(P_RIN));
      end
      5'b01100: begin
        push(K_IR, b(P_GRB) | b(P_ROUT) | b(P_YIN));
        push(K_IR, b(P_GRC) | b(P_ROUT) | b(P_ZIN));
        push(K_IR, b(P_ZLO) | b(P_LOIN));
        push(K_IR, b(P_ZHI) | b(P_HIIN));
      end
      5'b01001, 5'b01010, 5'b01011: begin
        push(K_IR, b(P_GRB) | b(P_ROUT) | b(P_YIN));
        push(K_IR, b(P_COUT) | b(P_ZIN));
        push(K_IR, b(P_ZLO) | b(P_GRA) | b(P_RIN));
      end
      5'b00001, 5'b00000, 5'b00010: begin
        push(K_IR,  b(P_GRB) | b(P_BAOUT) | b(P_YIN));
        push(K_ADD, b(P_COUT) | b(P_ZIN));
        if (op == 5'b00001) begin
          push(K_IR, b(P_ZLO) | b(P_GRA) | b(P_RIN));
        end else if (op == 5'b00000) begin
          push(K_IR, b(P_ZLO) | b(P_MARIN));
          push(K_IR, b(P_READ) | b(P_MDRIN));
          push(K_IR, b(P_MDROUT) | b(P_GRA) | b(P_RIN));
        end else begin
          push(K_IR, b(P_ZLO) | b(P_MARIN));
          push(K_IR, b(P_GRA) | b(P_ROUT) | b(P_MDRIN));
          push(K_IR, b(P_WRITE));
        end
      end
      5'b10010: begin
        push(K_IR,  b(P_GRA) | b(P_ROUT) | b(P_CONIN));
        push(K_IR,  b(P_PCOUT) | b(P_YIN));
        push(K_ADD, b(P_COUT) | b(P_ZIN));
        push(K_IR,  b(P_ZLO) | (con ? b(P_PCIN) : 27'b0));
      end
      5'b10011: push(K_IR, b(P_GRA) | b(P_ROUT) | b(P_PCIN));
      5'b10101: push(K_IR, b(P_INP) | b(P_GRA) | b(P_RIN));
      5'b10110: push(K_IR, b(P_GRA) | b(P_ROUT) | b(P_OUTP));
      5'b10111: push(K_IR, b(P_HIOUT) | b(P_GRA) | b(P_RIN));
      5'b11000: push(K_IR, b(P_LOOUT) | b(P_GRA) | b(P_RIN));
      5'b11001: push(K_IR, 27'b0);
      5'b11010: begin push(K_IR, 27'b0); op_halt = 1'b1; end
      default:  begin push(K_IR, 27'b0); op_ill = 1'b1; end
    endcase
  endtask

  // Hold clear for n edges, checking RESET after each, then release.
  task automatic do_reset(input int n);
    clear = 1'b1;
    stop  = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("reset d1", obs1, ZERO_V);
      chk("reset d0", obs0, ZERO_V);
    end
    clear = 1'b0;
  endtask

  task automatic run_instr(input logic [4:0] op, input logic con, input int stop_from,
                           input int pulse_at, input int clear_at);
    int last;
    int sf;
    bit h1, h0;
    logic [32:0] t0v;
    build(op, con);
    last = exp_q.size() - 1;
    sf   = (stop_from > last) ? last : stop_from;
    t0v  = {1'b1, 5'b0, b(P_PCOUT) | b(P_MARIN)};
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      chk($sformatf("d1 op%b step%0d", op, i), obs1, expv(exp_q[i], op, ADD1));
      chk($sformatf("d0 op%b step%0d", op, i), obs0, expv(exp_q[i], op, ADD0));
      if (i == 0) begin
        ir_opcode = op;
        con_ff    = con;
      end
      stop = (sf >= 0 && i >= sf) || (i == pulse_at && i != last);
      if (i == clear_at) begin
        clear = 1'b1;
        stop  = 1'b0;
        @(negedge clk);
        chk($sformatf("d1 abort op%b", op), obs1, ZERO_V);
        chk($sformatf("d0 abort op%b", op), obs0, ZERO_V);
        clear = 1'b0;
        return;
      end
    end
    h1 = op_halt || op_ill || (sf >= 0);
    h0 = op_halt || (sf >= 0);
    if (h1 || h0) begin
      @(negedge clk);
      stop = 1'b0;
      chk($sformatf("d1 end op%b", op), obs1, h1 ? ZERO_V : t0v);
      chk($sformatf("d0 end op%b", op), obs0, h0 ? ZERO_V : t0v);
      if (h1 && h0) begin
        @(negedge clk);
        chk("d1 halted hold", obs1, ZERO_V);
        chk("d0 halted hold", obs0, ZERO_V);
      end
      do_reset(1);
    end
  endtask

  initial begin
    logic [4:0] op;
    int sf, pa, ca;
    legal = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101, 5'b00110,
              5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01100, 5'b10010,
              5'b10011, 5'b10101, 5'b10110, 5'b10111, 5'b11000, 5'b11001, 5'b11010};

    do_reset(2);
    run_instr(5'b00011, 1'b0, -1, -1, -1);
    run_instr(5'b10010, 1'b1, -1, -1, -1);
    run_instr(5'b10010, 1'b0, -1, -1, -1);
    run_instr(5'b00010, 1'b0, -1, -1, -1);
    run_instr(5'b00010, 1'b0, -1, -1, 6);
    run_instr(5'b00000, 1'b0, 4, -1, -1);
    run_instr(5'b11111, 1'b0, -1, -1, -1);
    run_instr(5'b11010, 1'b0, -1, -1, -1);
    run_instr(5'b01100, 1'b1, -1, 4, -1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 4) == 0) op = 5'($urandom_range(0, 31));
      else                           op = legal[$urandom_range(0, 20)];
      sf = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1;
      pa = int'($urandom_range(0, 9));
      ca = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : -1;
      run_instr(op, 1'($urandom_range(0, 1)), sf, pa, ca);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
